// File: rtl/ifetch_prefetch.sv
// ----------------------------------------------------------------------------
// ifetch_prefetch
//
// Sequential instruction prefetcher between a CPU instruction bus (Wishbone
// slave side) and instruction memory (Wishbone master side, read-only).
// The block runs ahead of the CPU, fetching consecutive words into a small
// FIFO. Requests whose address matches the head of the stream are answered
// combinationally from the FIFO. Any other address restarts the stream there.
//
// Parameters
//   DEPTH      number of 32-bit FIFO entries (power of two, 2..16)
//
// Ports
//   clk_i      single clock
//   rst_i      synchronous active-high reset
//   flush_i    invalidate the stream and the FIFO
//   s_cyc_i    CPU bus cycle
//   s_stb_i    CPU bus strobe
//   s_adr_i    CPU fetch address (bits [1:0] ignored)
//   s_ack_o    fetch acknowledge (combinational)
//   s_dat_o    instruction word, zero when not acknowledging
//   m_cyc_o    memory bus cycle
//   m_stb_o    memory bus strobe
//   m_adr_o    memory word address
//   m_sel_o    byte selects, always all four
//   m_we_o     write enable, always low
//   m_ack_i    memory acknowledge
//   m_dat_i    memory read data
// ----------------------------------------------------------------------------
module ifetch_prefetch #(
    parameter int DEPTH = 4
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        flush_i,
    input  logic        s_cyc_i,
    input  logic        s_stb_i,
    input  logic [31:0] s_adr_i,
    output logic        s_ack_o,
    output logic [31:0] s_dat_o,
    output logic        m_cyc_o,
    output logic        m_stb_o,
    output logic [31:0] m_adr_o,
    output logic [3:0]  m_sel_o,
    output logic        m_we_o,
    input  logic        m_ack_i,
    input  logic [31:0] m_dat_i
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    logic          r_valid;
    logic          r_busy;
    logic          r_discard;
    logic [CW-1:0] r_count;
    logic [31:0]   r_headAddr;
    logic [31:0]   r_fetchAddr;
    logic [PW-1:0] r_rdPtr;
    logic [PW-1:0] r_wrPtr;
    logic [31:0]   r_mem [DEPTH];
    logic          r_mCyc;
    logic          r_mStb;
    logic [31:0]   r_mAdr;

    logic [31:0]   w_reqAddr;
    logic          w_req;
    logic          w_hit;
    logic          w_miss;
    logic          w_ack;
    logic          w_memAck;
    logic          w_push;
    logic          w_pop;
    logic          w_issue;
    logic          w_unused;

    // Request decode. The byte offset of the CPU address is dropped so all
    // comparisons and restarts work on word addresses. A hit only produces an
    // acknowledge when data is actually waiting, and a flush always wins.
    // A memory acknowledge only counts while a cycle is in flight; the data
    // is kept only when it still belongs to the current stream (no pending
    // discard, no flush or restart this very cycle). New memory requests are
    // held back during a flush or restart so a stale address is never issued.
    always_comb begin
        w_reqAddr = {s_adr_i[31:2], 2'b00};
        w_req     = s_cyc_i & s_stb_i;
        w_hit     = w_req & r_valid & (w_reqAddr == r_headAddr);
        w_miss    = w_req & ~w_hit;
        w_ack     = w_hit & (r_count != '0) & ~flush_i;
        w_memAck  = r_busy & m_ack_i;
        w_push    = w_memAck & ~r_discard & ~flush_i & ~w_miss;
        w_pop     = w_ack;
        w_issue   = r_valid & ~r_busy & (r_count < FULL) & ~flush_i & ~w_miss;
        w_unused  = &{1'b0, s_adr_i[1:0]};
    end

    assign s_ack_o = w_ack;
    assign s_dat_o = w_ack ? r_mem[r_rdPtr] : 32'h0;
    assign m_cyc_o = r_mCyc;
    assign m_stb_o = r_mStb;
    assign m_adr_o = r_mAdr;
    assign m_sel_o = 4'hf;
    assign m_we_o  = 1'b0;

    // Memory-side handshake. One request is outstanding at a time; the
    // strobe drops for a cycle after each acknowledge, which gives one word
    // every two cycles against zero-wait memory. Address and strobe stay
    // frozen while waiting for the acknowledge.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_busy <= 1'b0;
            r_mCyc <= 1'b0;
            r_mStb <= 1'b0;
            r_mAdr <= 32'h0;
        end else if (w_memAck) begin
            r_busy <= 1'b0;
            r_mCyc <= 1'b0;
            r_mStb <= 1'b0;
        end else if (w_issue) begin
            r_busy <= 1'b1;
            r_mCyc <= 1'b1;
            r_mStb <= 1'b1;
            r_mAdr <= r_fetchAddr;
        end
    end

    // Stream and FIFO bookkeeping. Flush beats restart, restart beats normal
    // push/pop. On flush or restart a memory cycle that is still waiting for
    // its acknowledge gets marked for discard, so its data never lands in the
    // new stream; if the acknowledge arrives in that same cycle the word is
    // simply not pushed and nothing needs to be remembered. Address arithmetic
    // wraps naturally at 32 bits.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_valid     <= 1'b0;
            r_discard   <= 1'b0;
            r_count     <= '0;
            r_headAddr  <= 32'h0;
            r_fetchAddr <= 32'h0;
            r_rdPtr     <= '0;
            r_wrPtr     <= '0;
        end else if (flush_i) begin
            r_valid   <= 1'b0;
            r_count   <= '0;
            r_rdPtr   <= '0;
            r_wrPtr   <= '0;
            r_discard <= r_busy & ~m_ack_i;
        end else if (w_miss) begin
            r_valid     <= 1'b1;
            r_count     <= '0;
            r_rdPtr     <= '0;
            r_wrPtr     <= '0;
            r_headAddr  <= w_reqAddr;
            r_fetchAddr <= w_reqAddr;
            r_discard   <= r_busy & ~m_ack_i;
        end else begin
            if (w_memAck) begin
                r_discard <= 1'b0;
            end
            if (w_push) begin
                r_wrPtr     <= r_wrPtr + PW'(1);
                r_fetchAddr <= r_fetchAddr + 32'd4;
            end
            if (w_pop) begin
                r_rdPtr    <= r_rdPtr + PW'(1);
                r_headAddr <= r_headAddr + 32'd4;
            end
            r_count <= r_count + CW'(w_push) - CW'(w_pop);
        end
    end

    // FIFO storage. Contents are only ever read behind a non-zero count, so
    // the array carries no reset.
    always_ff @(posedge clk_i) begin
        if (w_push) begin
            r_mem[r_wrPtr] <= m_dat_i;
        end
    end

endmodule

// File: tb/tb_ifetch_prefetch.sv
// ----------------------------------------------------------------------------
// tb_ifetch_prefetch
//
// Directed testbench for ifetch_prefetch. The memory model returns the
// bitwise inverse of the requested address, either acknowledging every strobe
// immediately (autoAck) or not at all, plus a forced acknowledge for stray
// handshakes. Inputs change 1 time unit after the rising edge; outputs are
// sampled after inputs have settled, well before the next edge.
// ----------------------------------------------------------------------------
module tb_ifetch_prefetch;

    localparam int DEPTH = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        sCyc;
    logic        sStb;
    logic [31:0] sAdr;
    logic        sAck;
    logic [31:0] sDat;
    logic        mCyc;
    logic        mStb;
    logic [31:0] mAdr;
    logic [3:0]  mSel;
    logic        mWe;
    logic        mAck;
    logic [31:0] mDat;
    logic        autoAck;
    logic        forceAck;

    int nChecks = 0;
    int nPass = 0;
    int maxCount = 0;

    ifetch_prefetch #(.DEPTH(DEPTH)) dut (
        .clk_i   (clk),
        .rst_i   (rst),
        .flush_i (flush),
        .s_cyc_i (sCyc),
        .s_stb_i (sStb),
        .s_adr_i (sAdr),
        .s_ack_o (sAck),
        .s_dat_o (sDat),
        .m_cyc_o (mCyc),
        .m_stb_o (mStb),
        .m_adr_o (mAdr),
        .m_sel_o (mSel),
        .m_we_o  (mWe),
        .m_ack_i (mAck),
        .m_dat_i (mDat)
    );

    // Clock and the zero-wait memory model.
    always #5 clk = ~clk;
    assign mAck = (autoAck & mStb) | forceAck;
    assign mDat = ~mAdr;

    // Track the deepest the prefetcher ever runs ahead of the CPU.
    always @(posedge clk) begin
        if (int'(dut.r_count) > maxCount) maxCount = int'(dut.r_count);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        nChecks++;
        if (observed !== expected) begin
            $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
        end else begin
            nPass++;
        end
    endtask

    task automatic applyStimulus(input logic req, input logic [31:0] adr);
        sCyc = req;
        sStb = req;
        sAdr = adr;
    endtask

    task automatic applyReset();
        rst = 1'b1;
        flush = 1'b0;
        autoAck = 1'b0;
        forceAck = 1'b0;
        applyStimulus(1'b0, 32'h0);
        step();
        step();
        rst = 1'b0;
    endtask

    // Present a fetch and wait (bounded) for the acknowledge, then check the
    // returned word against the memory model and release the bus.
    task automatic readWord(input logic [31:0] adr);
        int n = 0;
        applyStimulus(1'b1, adr);
        settle();
        while (!sAck && n < 40) begin
            step();
            settle();
            n++;
        end
        checkOutput("readAck", 32'(sAck), 32'h1);
        checkOutput("readData", sDat, ~adr);
        step();
        applyStimulus(1'b0, 32'h0);
    endtask

    initial begin
        logic [31:0] seen [3];
        int got;

        // Reset state
        applyReset();
        settle();
        checkOutput("rstAck", 32'(sAck), 32'h0);
        checkOutput("rstDat", sDat, 32'h0);
        checkOutput("rstCyc", 32'(mCyc), 32'h0);
        checkOutput("rstStb", 32'(mStb), 32'h0);
        checkOutput("rstAdr", mAdr, 32'h0);
        checkOutput("sel", 32'(mSel), 32'hf);
        checkOutput("we", 32'(mWe), 32'h0);

        // Cold start: ack three cycles after the first request
        autoAck = 1'b1;
        applyStimulus(1'b1, 32'h7000_0000);
        settle();
        checkOutput("coldMissAck", 32'(sAck), 32'h0);
        step();
        settle();
        checkOutput("coldNoStbYet", 32'(mStb), 32'h0);
        checkOutput("coldWaitAck", 32'(sAck), 32'h0);
        step();
        checkOutput("coldStb", 32'(mStb), 32'h1);
        checkOutput("coldAdr", mAdr, 32'h7000_0000);
        step();
        settle();
        checkOutput("coldAck", 32'(sAck), 32'h1);
        checkOutput("coldData", sDat, 32'h8FFF_FFFF);
        step();
        applyStimulus(1'b0, 32'h0);

        // Sequential stream: prefetcher fills up and stops, then the CPU
        // drains 15 more words one request every two cycles
        repeat (20) step();
        checkOutput("fullCount", 32'(dut.r_count), 32'(DEPTH));
        checkOutput("fullNoStb", 32'(mStb), 32'h0);
        checkOutput("fullLastAdr", mAdr, 32'h7000_0020);
        for (int k = 1; k < 16; k++) begin
            readWord(32'h7000_0000 + 32'(4 * k));
            step();
        end
        checkOutput("maxAhead", 32'(maxCount <= DEPTH), 32'h1);

        // Branch miss with four words buffered and one cycle in flight
        applyReset();
        autoAck = 1'b1;
        applyStimulus(1'b1, 32'h0000_0100);
        step();
        applyStimulus(1'b0, 32'h0);
        repeat (9) step();
        autoAck = 1'b0;
        checkOutput("brInFlightStb", 32'(mStb), 32'h1);
        checkOutput("brInFlightAdr", mAdr, 32'h0000_0110);
        checkOutput("brCount4", 32'(dut.r_count), 32'h4);
        applyStimulus(1'b1, 32'h0000_2000);
        settle();
        checkOutput("brMissAck", 32'(sAck), 32'h0);
        step();
        checkOutput("brCount0", 32'(dut.r_count), 32'h0);
        checkOutput("brHeldAdr", mAdr, 32'h0000_0110);
        autoAck = 1'b1;
        step();
        checkOutput("brGapStb", 32'(mStb), 32'h0);
        step();
        checkOutput("brNewStb", 32'(mStb), 32'h1);
        checkOutput("brNewAdr", mAdr, 32'h0000_2000);
        step();
        settle();
        checkOutput("brAck", 32'(sAck), 32'h1);
        checkOutput("brData", sDat, 32'hFFFF_DFFF);
        step();
        applyStimulus(1'b0, 32'h0);

        // Address wrap at the top of memory
        applyReset();
        autoAck = 1'b1;
        applyStimulus(1'b1, 32'hFFFF_FFF8);
        step();
        applyStimulus(1'b0, 32'h0);
        got = 0;
        for (int n = 0; n < 20 && got < 3; n++) begin
            step();
            if (mStb && mAck) begin
                seen[got] = mAdr;
                got++;
            end
        end
        checkOutput("wrapBeats", 32'(got), 32'h3);
        checkOutput("wrapAdr0", seen[0], 32'hFFFF_FFF8);
        checkOutput("wrapAdr1", seen[1], 32'hFFFF_FFFC);
        checkOutput("wrapAdr2", seen[2], 32'h0000_0000);
        readWord(32'hFFFF_FFF8);
        readWord(32'hFFFF_FFFC);
        readWord(32'h0000_0000);

        // Flush coincident with a hit and a push
        applyReset();
        autoAck = 1'b1;
        applyStimulus(1'b1, 32'h0000_0400);
        step();
        applyStimulus(1'b0, 32'h0);
        step();
        step();
        step();
        applyStimulus(1'b1, 32'h0000_0400);
        flush = 1'b1;
        settle();
        checkOutput("flPushSameCycle", 32'(mAck), 32'h1);
        checkOutput("flAckBlocked", 32'(sAck), 32'h0);
        step();
        flush = 1'b0;
        checkOutput("flCount", 32'(dut.r_count), 32'h0);
        checkOutput("flValid", 32'(dut.r_valid), 32'h0);
        settle();
        checkOutput("flMissAck", 32'(sAck), 32'h0);
        step();
        step();
        checkOutput("flRefetchStb", 32'(mStb), 32'h1);
        checkOutput("flRefetchAdr", mAdr, 32'h0000_0400);
        step();
        settle();
        checkOutput("flAck", 32'(sAck), 32'h1);
        checkOutput("flData", sDat, 32'hFFFF_FBFF);
        step();
        applyStimulus(1'b0, 32'h0);

        // Reset in the middle of a memory cycle, then a late acknowledge
        applyReset();
        applyStimulus(1'b1, 32'h0000_0800);
        step();
        applyStimulus(1'b0, 32'h0);
        step();
        checkOutput("rmStb", 32'(mStb), 32'h1);
        checkOutput("rmAdr", mAdr, 32'h0000_0800);
        rst = 1'b1;
        step();
        rst = 1'b0;
        checkOutput("rmCyc0", 32'(mCyc), 32'h0);
        checkOutput("rmStb0", 32'(mStb), 32'h0);
        checkOutput("rmAdr0", mAdr, 32'h0);
        checkOutput("rmAck0", 32'(sAck), 32'h0);
        checkOutput("rmDat0", sDat, 32'h0);
        forceAck = 1'b1;
        step();
        forceAck = 1'b0;
        checkOutput("lateNoPush", 32'(dut.r_count), 32'h0);
        checkOutput("lateNoCyc", 32'(mCyc), 32'h0);
        settle();
        checkOutput("lateNoAck", 32'(sAck), 32'h0);

        $display("[TB] %0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

endmodule
